cpu_phase_sequencer: RTL and testbench

Parametrised multi-cycle phase sequencer for the Avalon memory-mapped MIPS CPU, the next generation of the fixed five-state control sequence. It selects a per-instruction phase path: ALU ops skip memory access, stores skip write-back, and branches and jumps retire from EXECUTE. It holds FETCH and MEMORY_ACCESS while the Avalon bus asserts waitrequest, guards those waits with a watchdog, and supports a clean halt. It sits between the instruction decoder and the datapath/bus-master enables.

---
 rtl/cpu_phase_sequencer_if.sv | 27 ++
 rtl/cpu_phase_sequencer.sv | 158 +++++++++++++++
 tb/tb_cpu_phase_sequencer.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/cpu_phase_sequencer_if.sv
// cpu_phase_sequencer_if: decoder/bus-facing signal bundle for the phase sequencer.
// The master side is the decoder/bus side; the sequencer connects through the slave modport.
interface cpu_phase_sequencer_if #(
    parameter int unsigned CNT_W = 32
);
    logic             stall;
    logic             waitrequest;
    logic [1:0]       instr_class;
    logic             instr_link;
    logic             halt_req;
    logic [2:0]       state;
    logic             active;
    logic             instr_done;
    logic             wait_error;
    logic [CNT_W-1:0] instr_count;
    logic [CNT_W-1:0] stall_count;

    modport master (
        output stall, waitrequest, instr_class, instr_link, halt_req,
        input  state, active, instr_done, wait_error, instr_count, stall_count
    );

    modport slave (
        input  stall, waitrequest, instr_class, instr_link, halt_req,
        output state, active, instr_done, wait_error, instr_count, stall_count
    );
endinterface

// File: rtl/cpu_phase_sequencer.sv
// cpu_phase_sequencer: per-instruction multi-cycle phase control for the Avalon MIPS CPU.
// Holds FETCH/MEMORY_ACCESS on waitrequest with a watchdog, supports clean halt.
// Optional feature macro: SEQ_PERF_CNT_EN builds the retired-instruction and stall counters;
// without it both counter outputs are tied to zero.
module cpu_phase_sequencer #(
    parameter int unsigned WAIT_LIMIT = 16,
    parameter int unsigned WAIT_W     = 8,
    parameter int unsigned CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    cpu_phase_sequencer_if.slave  bus
);

    typedef enum logic [2:0] {
        ST_FETCH   = 3'd0,
        ST_DECODE  = 3'd1,
        ST_EXECUTE = 3'd2,
        ST_MEMORY  = 3'd3,
        ST_WRITEBK = 3'd4,
        ST_HALTED  = 3'd5
    } state_e;

    localparam logic [1:0] CLS_ALU   = 2'd0;
    localparam logic [1:0] CLS_LOAD  = 2'd1;
    localparam logic [1:0] CLS_STORE = 2'd2;

    // Last tolerated wait count before the watchdog fires.
    localparam logic [WAIT_W-1:0] WAIT_LAST =
        WAIT_W'((WAIT_LIMIT == 32'd0) ? 32'd0 : WAIT_LIMIT - 32'd1);

    state_e            state_q, state_d;
    logic [1:0]        cls_q, cls_d;
    logic              lnk_q, lnk_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              active_q, active_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              retire_c;
    logic              bus_phase_c;

    assign bus_phase_c = (state_q == ST_FETCH) || (state_q == ST_MEMORY);

    // Next-state, watchdog and retirement decode in priority order.
    always_comb begin
        state_d    = state_q;
        cls_d      = cls_q;
        lnk_d      = lnk_q;
        wait_cnt_d = '0;
        err_d      = err_q;
        done_d     = 1'b0;
        retire_c   = 1'b0;

        if (state_q == ST_HALTED) begin
            state_d = ST_HALTED;
        end else if (bus.stall) begin
            wait_cnt_d = wait_cnt_q;
        end else if (bus_phase_c && bus.waitrequest) begin
            if ((WAIT_LIMIT != 32'd0) && (wait_cnt_q == WAIT_LAST)) begin
                state_d = ST_HALTED;
                err_d   = 1'b1;
            end else begin
                wait_cnt_d = wait_cnt_q + WAIT_W'(1);
            end
        end else begin
            case (state_q)
                ST_FETCH:   state_d = ST_DECODE;
                ST_DECODE: begin
                    state_d = ST_EXECUTE;
                    cls_d   = bus.instr_class;
                    lnk_d   = bus.instr_link;
                end
                ST_EXECUTE: begin
                    if ((cls_q == CLS_LOAD) || (cls_q == CLS_STORE)) begin
                        state_d = ST_MEMORY;
                    end else if ((cls_q == CLS_ALU) || lnk_q) begin
                        state_d = ST_WRITEBK;
                    end else begin
                        retire_c = 1'b1;
                    end
                end
                ST_MEMORY: begin
                    if (cls_q == CLS_LOAD) begin
                        state_d = ST_WRITEBK;
                    end else begin
                        retire_c = 1'b1;
                    end
                end
                ST_WRITEBK: retire_c = 1'b1;
                default:    state_d = ST_FETCH;
            endcase

            if (retire_c) begin
                state_d = bus.halt_req ? ST_HALTED : ST_FETCH;
                done_d  = 1'b1;
            end
        end

        active_d = (state_d != ST_HALTED);
    end

    // Sequencer state and registered status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_FETCH;
            cls_q      <= 2'd0;
            lnk_q      <= 1'b0;
            wait_cnt_q <= '0;
            active_q   <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cls_q      <= cls_d;
            lnk_q      <= lnk_d;
            wait_cnt_q <= wait_cnt_d;
            active_q   <= active_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign bus.state      = state_q;
    assign bus.active     = active_q;
    assign bus.instr_done = done_q;
    assign bus.wait_error = err_q;

`ifdef SEQ_PERF_CNT_EN
    logic [CNT_W-1:0] instr_cnt_q;
    logic [CNT_W-1:0] stall_cnt_q;
    logic             stall_inc_c;

    assign stall_inc_c = (state_q != ST_HALTED) &&
                         (bus.stall || (bus_phase_c && bus.waitrequest));

    // Retirement and stall/wait cycle counters, wrapping naturally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (retire_c) begin
                instr_cnt_q <= instr_cnt_q + CNT_W'(1);
            end
            if (stall_inc_c) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
        end
    end

    assign bus.instr_count = instr_cnt_q;
    assign bus.stall_count = stall_cnt_q;
`else
    assign bus.instr_count = '0;
    assign bus.stall_count = '0;
`endif

endmodule

// File: tb/tb_cpu_phase_sequencer.sv
// tb_cpu_phase_sequencer: table-driven directed check of the phase sequencer (WAIT_LIMIT=4),
// plus hand-written reset/halt sequences.
module tb_cpu_phase_sequencer;

`ifdef SEQ_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    typedef struct {
        logic        stall;
        logic        wr;
        logic [1:0]  cls;
        logic        lnk;
        logic        halt;
        logic [2:0]  st;
        logic        act;
        logic        done;
        logic        err;
        int unsigned icnt;
        int unsigned scnt;
    } vec_t;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    vec_t vq[$];

    cpu_phase_sequencer_if #(.CNT_W(32)) bus ();

    cpu_phase_sequencer #(
        .WAIT_LIMIT (4),
        .WAIT_W     (8),
        .CNT_W      (32)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic add(input int s, input int w, input int c, input int l, input int h,
                       input int st, input int a, input int d, input int e,
                       input int ic, input int sc);
        vec_t v;
        v.stall = 1'(s);  v.wr = 1'(w);   v.cls = 2'(c);  v.lnk = 1'(l); v.halt = 1'(h);
        v.st    = 3'(st); v.act = 1'(a);  v.done = 1'(d); v.err = 1'(e);
        v.icnt  = 32'(ic); v.scnt = 32'(sc);
        vq.push_back(v);
    endtask

    task automatic drive(input logic s, input logic w, input logic [1:0] c,
                         input logic l, input logic h);
        bus.stall       = s;
        bus.waitrequest = w;
        bus.instr_class = c;
        bus.instr_link  = l;
        bus.halt_req    = h;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input string tag, input logic [2:0] st, input logic a,
                              input logic d, input logic e, input int unsigned ic,
                              input int unsigned sc);
        check({tag, " state"},       32'(bus.state),       32'(st));
        check({tag, " active"},      32'(bus.active),      32'(a));
        check({tag, " instr_done"},  32'(bus.instr_done),  32'(d));
        check({tag, " wait_error"},  32'(bus.wait_error),  32'(e));
        check({tag, " instr_count"}, bus.instr_count,      PERF ? ic : 32'd0);
        check({tag, " stall_count"}, bus.stall_count,      PERF ? sc : 32'd0);
    endtask

    // Async reset asserted mid-cycle: outputs must clear before any clock edge.
    task automatic async_reset(input string tag);
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check_outs(tag, 3'd0, 1'b1, 1'b0, 1'b0, 0, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        drive(1'b0, 1'b0, 2'd0, 1'b0, 1'b0);

        //   stall wr cls lnk halt | state act done err icnt scnt
        // ALU, no waits
        add(0,0,0,0,0, 1,1,0,0, 0,0);
        add(0,0,0,0,0, 2,1,0,0, 0,0);
        add(0,0,0,0,0, 4,1,0,0, 0,0);
        add(0,0,0,0,0, 0,1,1,0, 1,0);
        // LOAD, 3 waits in MEMORY_ACCESS, stray halt pulse ignored
        add(0,0,0,0,0, 1,1,0,0, 1,0);
        add(0,0,1,0,0, 2,1,0,0, 1,0);
        add(0,0,0,0,0, 3,1,0,0, 1,0);
        add(0,1,0,0,0, 3,1,0,0, 1,1);
        add(0,1,0,0,1, 3,1,0,0, 1,2);
        add(0,1,0,0,0, 3,1,0,0, 1,3);
        add(0,0,0,0,0, 4,1,0,0, 1,3);
        add(0,0,0,0,0, 0,1,1,0, 2,3);
        // branch without link; class changing after DECODE is ignored
        add(0,0,0,0,0, 1,1,0,0, 2,3);
        add(0,0,3,0,0, 2,1,0,0, 2,3);
        add(0,0,1,0,0, 0,1,1,0, 3,3);
        // linked branch
        add(0,0,0,0,0, 1,1,0,0, 3,3);
        add(0,0,3,1,0, 2,1,0,0, 3,3);
        add(0,0,0,0,0, 4,1,0,0, 3,3);
        add(0,0,0,0,0, 0,1,1,0, 4,3);
        // STORE: one fetch wait, 5-cycle stall in EXECUTE, skips WRITE_BACK
        add(0,1,0,0,0, 0,1,0,0, 4,4);
        add(0,0,0,0,0, 1,1,0,0, 4,4);
        add(0,0,2,0,0, 2,1,0,0, 4,4);
        add(1,0,0,0,0, 2,1,0,0, 4,5);
        add(1,0,0,0,0, 2,1,0,0, 4,6);
        add(1,0,0,0,0, 2,1,0,0, 4,7);
        add(1,0,0,0,0, 2,1,0,0, 4,8);
        add(1,0,0,0,0, 2,1,0,0, 4,9);
        add(0,0,0,0,0, 3,1,0,0, 4,9);
        add(0,0,0,0,0, 0,1,1,0, 5,9);
        // ALU with a stall in WRITE_BACK delaying retirement
        add(0,0,0,0,0, 1,1,0,0, 5,9);
        add(0,0,0,0,0, 2,1,0,0, 5,9);
        add(0,0,0,0,0, 4,1,0,0, 5,9);
        add(1,0,0,0,0, 4,1,0,0, 5,10);
        add(0,0,0,0,0, 0,1,1,0, 6,10);
        // stuck fetch wait; stall freezes the watchdog, 4th wait cycle halts
        add(0,1,0,0,0, 0,1,0,0, 6,11);
        add(0,1,0,0,0, 0,1,0,0, 6,12);
        add(1,1,0,0,0, 0,1,0,0, 6,13);
        add(0,1,0,0,0, 0,1,0,0, 6,14);
        add(0,1,0,0,0, 5,0,0,1, 6,15);
        // HALTED absorbs everything, including stall
        add(1,0,0,0,1, 5,0,0,1, 6,15);

        #1 reset = 1'b1;
        step();
        step();
        check_outs("reset", 3'd0, 1'b1, 1'b0, 1'b0, 0, 0);
        reset = 1'b0;

        foreach (vq[i]) begin
            drive(vq[i].stall, vq[i].wr, vq[i].cls, vq[i].lnk, vq[i].halt);
            step();
            check_outs($sformatf("vec%0d", i), vq[i].st, vq[i].act, vq[i].done,
                       vq[i].err, vq[i].icnt, vq[i].scnt);
        end

        // Reset out of HALTED clears the sticky error immediately.
        drive(1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
        async_reset("reset_from_watchdog");

        // Reset mid-instruction abandons it with no retirement.
        step();
        step();
        check_outs("abandon_pre", 3'd2, 1'b1, 1'b0, 1'b0, 0, 0);
        async_reset("reset_mid_instr");
        step();
        check_outs("abandon_post", 3'd1, 1'b1, 1'b0, 1'b0, 0, 0);

        // halt_req sampled on the WRITE_BACK boundary of an ALU op.
        step();
        check_outs("halt_ex", 3'd2, 1'b1, 1'b0, 1'b0, 0, 0);
        step();
        check_outs("halt_wb", 3'd4, 1'b1, 1'b0, 1'b0, 0, 0);
        drive(1'b0, 1'b0, 2'd0, 1'b0, 1'b1);
        step();
        check_outs("halt_enter", 3'd5, 1'b0, 1'b1, 1'b0, 1, 0);
        drive(1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
        step();
        check_outs("halt_hold", 3'd5, 1'b0, 1'b0, 1'b0, 1, 0);
        async_reset("reset_from_halt");
        step();
        check_outs("restart", 3'd1, 1'b1, 1'b0, 1'b0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
